// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its register-file sequencer:
// opcodes, sequencer state encoding and default widths.
package alu_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SRL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// 2^AW x DW register file: two combinational read ports, one synchronous
// write port, r0 hardwired to zero, synchronous clear on reset.
module reg_file_2r1w #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = (i_raddr0 == '0) ? '0 : r_mem[i_raddr0];
    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];

endmodule

// File: rtl/alu_reg_seq.sv
// Four-state operand fetch / execute / write-back sequencer that drives an
// external combinational ALU from a 2R1W register file.
module alu_reg_seq
    import alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    input  logic [2:0]    op,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_f,
    input  logic          alu_zf,
    input  logic          alu_of,
    output logic          busy,
    output logic          done,
    output logic          zf_q,
    output logic          of_q,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    seq_state_t    r_state, w_next;
    logic [AW-1:0] r_rs1_q, r_rs2_q, r_rd_q;
    logic [2:0]    r_op_q, r_alu_op;
    logic [DW-1:0] r_a_q, r_b_q, r_f_q;
    logic          r_zf_n, r_of_n, r_zf_q, r_of_q, r_done;

    logic          w_we;
    logic [AW-1:0] w_waddr, w_raddr0;
    logic [DW-1:0] w_wdata, w_rdata0, w_rdata1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Port 0 serves the debug read except during FETCH, when it reads rs1.
    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_waddr  = ld_addr;
        w_wdata  = ld_data;
        w_raddr0 = dbg_addr;
        case (r_state)
            IDLE: begin
                w_we = ld_en;
                if (start) w_next = FETCH;
            end
            FETCH: begin
                w_raddr0 = r_rs1_q;
                w_next   = EXEC;
            end
            EXEC: w_next = WB;
            WB: begin
                w_we    = 1'b1;
                w_waddr = r_rd_q;
                w_wdata = r_f_q;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1_q  <= '0;
            r_rs2_q  <= '0;
            r_rd_q   <= '0;
            r_op_q   <= '0;
            r_alu_op <= '0;
            r_a_q    <= '0;
            r_b_q    <= '0;
            r_f_q    <= '0;
            r_zf_n   <= 1'b0;
            r_of_n   <= 1'b0;
            r_zf_q   <= 1'b0;
            r_of_q   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == WB);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rs1_q <= rs1;
                        r_rs2_q <= rs2;
                        r_rd_q  <= rd;
                        r_op_q  <= op;
                    end
                end
                // ALU inputs only change on entry to EXEC, so they hold otherwise.
                FETCH: begin
                    r_a_q    <= w_rdata0;
                    r_b_q    <= w_rdata1;
                    r_alu_op <= r_op_q;
                end
                EXEC: begin
                    r_f_q  <= alu_f;
                    r_zf_n <= alu_zf;
                    r_of_n <= alu_of;
                end
                WB: begin
                    r_zf_q <= r_zf_n;
                    r_of_q <= r_of_n;
                end
                default: ;
            endcase
        end
    end

    reg_file_2r1w #(.DW(DW), .AW(AW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr0 (w_raddr0),
        .i_raddr1 (r_rs2_q),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign alu_a    = r_a_q;
    assign alu_b    = r_b_q;
    assign alu_op   = r_alu_op;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign zf_q     = r_zf_q;
    assign of_q     = r_of_q;
    assign dbg_data = w_rdata0;

endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed bench for alu_reg_seq with a behavioural ALU attached alongside.
module tb_alu_reg_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, ld_en;
    logic [4:0]  rs1, rs2, rd, ld_addr, dbg_addr;
    logic [2:0]  op, alu_op;
    logic [31:0] ld_data, alu_a, alu_b, alu_f, dbg_data;
    logic        alu_zf, alu_of, busy, done, zf_q, of_q;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_reg_seq #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
        .op(op), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f),
        .alu_zf(alu_zf), .alu_of(alu_of), .busy(busy), .done(done),
        .zf_q(zf_q), .of_q(of_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU: F, ZF = (F==0), OF only for signed ADD/SUB overflow.
    always_comb begin
        alu_f  = '0;
        alu_of = 1'b0;
        case (alu_op)
            OP_AND:  alu_f = alu_a & alu_b;
            OP_OR:   alu_f = alu_a | alu_b;
            OP_XOR:  alu_f = alu_a ^ alu_b;
            OP_NOR:  alu_f = ~(alu_a | alu_b);
            OP_ADD: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            OP_SUB: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            OP_SLTU: alu_f = (alu_a < alu_b) ? 32'd1 : 32'd0;
            OP_SRL:  alu_f = alu_b >> alu_a[4:0];
            default: alu_f = '0;
        endcase
    end
    assign alu_zf = (alu_f == 32'd0);

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic        zf;
        logic        of;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Returns in the cycle done is high (FSM back in IDLE).
    task automatic run_op(input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [2:0] o);
        start = 1'b1; rs1 = s1; rs2 = s2; rd = d; op = o;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_low_k", {31'd0, done}, 32'd0);
        tick();
        tick();
        check("done_low_k2", {31'd0, done}, 32'd0);
        tick();
        check("done_k3", {31'd0, done}, 32'd1);
        check("busy_clear_k3", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] rv;
    int          n_done;

    initial begin
        vecs[0]  = '{OP_ADD,  5'd3,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB,  5'd4,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[2]  = '{OP_XOR,  5'd0,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3]  = '{OP_AND,  5'd9,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
        vecs[4]  = '{OP_OR,   5'd10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5]  = '{OP_NOR,  5'd11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6]  = '{OP_ADD,  5'd12, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[7]  = '{OP_ADD,  5'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8]  = '{OP_SLTU, 5'd14, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
        vecs[9]  = '{OP_SLTU, 5'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[10] = '{OP_SRL,  5'd16, 32'h0000_0004, 32'hF000_0000, 32'h0F00_0000, 1'b0, 1'b0};
        vecs[11] = '{OP_SUB,  5'd17, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; ld_en = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; op = '0;
        ld_addr = '0; ld_data = '0; dbg_addr = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_zf",   {31'd0, zf_q}, 32'd0);
        check("rst_of",   {31'd0, of_q}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        read_reg(5'd5, rv);
        check("rst_r5", rv, 32'd0);

        load(5'd0, 32'hFFFF_FFFF);
        read_reg(5'd0, rv);
        check("r0_load_discard", rv, 32'd0);

        for (int i = 0; i < 12; i++) begin
            load(5'd1, vecs[i].a);
            load(5'd2, vecs[i].b);
            run_op(5'd1, 5'd2, vecs[i].rd, vecs[i].op);
            read_reg(vecs[i].rd, rv);
            check($sformatf("vec%0d_f", i), rv, vecs[i].f);
            check($sformatf("vec%0d_zf", i), {31'd0, zf_q}, {31'd0, vecs[i].zf});
            check($sformatf("vec%0d_of", i), {31'd0, of_q}, {31'd0, vecs[i].of});
            check($sformatf("vec%0d_alu_a_hold", i), alu_a, vecs[i].a);
            check($sformatf("vec%0d_alu_b_hold", i), alu_b, vecs[i].b);
            check($sformatf("vec%0d_alu_op_hold", i), {29'd0, alu_op}, {29'd0, vecs[i].op});
        end

        // Dependent pair: second start issued in the done cycle of the first.
        load(5'd1, 32'd10);
        load(5'd2, 32'd20);
        load(5'd7, 32'd1);
        run_op(5'd1, 5'd2, 5'd5, OP_ADD);
        run_op(5'd7, 5'd5, 5'd6, OP_SRL);
        read_reg(5'd5, rv);
        check("b2b_r5", rv, 32'd30);
        read_reg(5'd6, rv);
        check("b2b_r6", rv, 32'd15);

        // start during EXEC and ld_en during FETCH must be ignored.
        load(5'd1, 32'd3);
        load(5'd2, 32'd4);
        start = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd18; op = OP_ADD;
        tick();
        start = 1'b0;
        ld_en = 1'b1; ld_addr = 5'd20; ld_data = 32'h55;
        tick();
        ld_en = 1'b0;
        start = 1'b1; rd = 5'd19; op = OP_OR;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) n_done++;
        end
        check("ignored_start_done_count", n_done, 32'd1);
        read_reg(5'd18, rv);
        check("ignored_start_r18", rv, 32'd7);
        read_reg(5'd19, rv);
        check("ignored_start_r19", rv, 32'd0);
        read_reg(5'd20, rv);
        check("ignored_load_r20", rv, 32'd0);

        // Reset during WB aborts the op and clears flags and registers.
        load(5'd1, 32'h1234_5678);
        run_op(5'd1, 5'd1, 5'd0, OP_XOR);
        check("pre_reset_zf", {31'd0, zf_q}, 32'd1);
        load(5'd8, 32'hDEAD_BEEF);
        read_reg(5'd8, rv);
        check("preload_r8", rv, 32'hDEAD_BEEF);
        start = 1'b1; rs1 = 5'd1; rs2 = 5'd1; rd = 5'd8; op = OP_ADD;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wb_rst_done", {31'd0, done}, 32'd0);
        check("wb_rst_busy", {31'd0, busy}, 32'd0);
        check("wb_rst_zf", {31'd0, zf_q}, 32'd0);
        read_reg(5'd8, rv);
        check("wb_rst_r8", rv, 32'd0);
        tick();
        check("wb_rst_done_next", {31'd0, done}, 32'd0);
        check("wb_rst_idle_next", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
